// File: rtl/gray_word_packer.sv
// Packs 8-bit grayscale pixels into 256-bit DDR3 write words. Each frame's words go to one of NUM_FRAMES slots in rotation.
// Completed words pass through one register stage and then a 2-entry valid/ready queue that absorbs MIG back-pressure.
module gray_word_packer #(
    parameter int PIXEL_WIDTH  = 8,
    parameter int WORD_WIDTH   = 256,
    parameter int ADDR_WIDTH   = 29,
    parameter int NUM_FRAMES   = 7,
    parameter int FRAME_WORDS  = 28800,
    parameter int ADDR_STEP    = 8,
    parameter int FRAME_STRIDE = 262144
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame_start,
    input  logic                   freeze,
    input  logic [PIXEL_WIDTH-1:0] pixel_in,
    input  logic                   pixel_valid,
    output logic [WORD_WIDTH-1:0]  word_data,
    output logic [ADDR_WIDTH-1:0]  word_addr,
    output logic                   word_valid,
    input  logic                   word_ready,
    output logic [2:0]             cur_slot,
    output logic                   overflow,
    output logic                   frame_overrun
);

    localparam int PIX_PER_WORD = WORD_WIDTH / PIXEL_WIDTH;
    localparam int CNT_W        = $clog2(PIX_PER_WORD);
    localparam int IDX_W        = $clog2(FRAME_WORDS + 1);

    localparam logic [CNT_W-1:0] LAST_PIX  = CNT_W'(PIX_PER_WORD - 1);
    localparam logic [IDX_W-1:0] IDX_FULL  = IDX_W'(FRAME_WORDS);
    localparam logic [2:0]       LAST_SLOT = 3'(NUM_FRAMES - 1);

    // Packer state
    logic                  writing;
    logic [CNT_W-1:0]      pix_cnt;
    logic [IDX_W-1:0]      word_idx;
    logic [WORD_WIDTH-1:0] acc;

    // Completed word waiting to enter the queue
    logic                  pend_valid;
    logic [WORD_WIDTH-1:0] pend_data;
    logic [ADDR_WIDTH-1:0] pend_addr;

    // Effective state for this cycle, with frame_start applied before the pixel
    logic                  writing_nxt;
    logic [2:0]            slot_nxt;
    logic [CNT_W-1:0]      cnt_base;
    logic [IDX_W-1:0]      idx_base;
    logic                  take;
    logic                  word_done;
    logic                  word_fits;
    logic [WORD_WIDTH-1:0] full_word;
    logic [ADDR_WIDTH-1:0] addr_nxt;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
        writing_nxt = writing;
        slot_nxt    = cur_slot;
        cnt_base    = pix_cnt;
        idx_base    = word_idx;
        if (frame_start) begin
            cnt_base    = '0;
            idx_base    = '0;
            writing_nxt = ~freeze;
            if (!freeze)
                slot_nxt = (cur_slot == LAST_SLOT) ? 3'd0 : cur_slot + 3'd1;
        end
        take      = pixel_valid & writing_nxt;
        word_done = take && (cnt_base == LAST_PIX);
        word_fits = idx_base < IDX_FULL;

        full_word = acc;
        full_word[(PIX_PER_WORD-1)*PIXEL_WIDTH +: PIXEL_WIDTH] = pixel_in;

        addr_nxt = ADDR_WIDTH'(slot_nxt) * ADDR_WIDTH'(FRAME_STRIDE)
                 + ADDR_WIDTH'(idx_base) * ADDR_WIDTH'(ADDR_STEP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_slot      <= LAST_SLOT;
            writing       <= 1'b0;
            pix_cnt       <= '0;
            word_idx      <= '0;
            acc           <= '0;
            pend_valid    <= 1'b0;
            pend_data     <= '0;
            pend_addr     <= '0;
            frame_overrun <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            cur_slot   <= slot_nxt;
            writing    <= writing_nxt;
            pend_valid <= 1'b0;
            if (frame_start) begin
                pix_cnt  <= '0;
                word_idx <= '0;
            end
            if (take) begin
                acc[cnt_base*PIXEL_WIDTH +: PIXEL_WIDTH] <= pixel_in;
                pix_cnt <= (cnt_base == LAST_PIX) ? '0 : cnt_base + 1'b1;
                if (word_done) begin
                    if (word_fits) begin
                        pend_valid <= 1'b1;
                        pend_data  <= full_word;
                        pend_addr  <= addr_nxt;
                        word_idx   <= idx_base + 1'b1;
                    end else begin
                        frame_overrun <= 1'b1;
                    end
                end
            end
        end
    end

    // Two-entry queue: head drives the outputs, tail holds the second word.
    logic [1:0]            q_cnt;
    logic [WORD_WIDTH-1:0] head_data, tail_data;
    logic [ADDR_WIDTH-1:0] head_addr, tail_addr;
    logic                  pop;

    assign word_valid = (q_cnt != 2'd0);
    assign word_data  = head_data;
    assign word_addr  = head_addr;
    assign pop        = word_valid & word_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the queue storage is only two registers, so it is reset along with its count and reads 0 after reset.
            q_cnt     <= 2'd0;
            head_data <= '0;
            head_addr <= '0;
            tail_data <= '0;
            tail_addr <= '0;
            overflow  <= 1'b0;
        end else if (pend_valid && !pop) begin
            case (q_cnt)
                2'd0: begin
                    head_data <= pend_data;
                    head_addr <= pend_addr;
                    q_cnt     <= 2'd1;
                end
                2'd1: begin
                    tail_data <= pend_data;
                    tail_addr <= pend_addr;
                    q_cnt     <= 2'd2;
                end
                default: overflow <= 1'b1;
            endcase
        end else if (pend_valid && pop) begin
            if (q_cnt == 2'd1) begin
                head_data <= pend_data;
                head_addr <= pend_addr;
            end else begin
                head_data <= tail_data;
                head_addr <= tail_addr;
                tail_data <= pend_data;
                tail_addr <= pend_addr;
            end
        end else if (pop) begin
            head_data <= tail_data;
            head_addr <= tail_addr;
            q_cnt     <= q_cnt - 2'd1;
        end
    end

endmodule
